key_decoder: RTL and testbench
==============================

// Module: key_decoder
// PURPOSE
//  Inverse of the key encoder: takes one packed key word (NBYTES characters, DW bits
//  each) and streams it back out one character per cycle. Each character is paired
//  with a memory address (base + index) for the downstream character buffer/lexicon.
//  Sits between the key store and the byte-wide text path of the speech NLP pipeline.
// PARAMETERS
//  NBYTES   10     characters per key word (word width = NBYTES*DW = 80)
//  DW       8      character width
//  AW       8      address width; addresses wrap modulo 2**AW
//  TERM     8'h00  terminator character
//  TERM_EN  1      1: stop the stream at the first TERM character (TERM not emitted)
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          synchronous, active-high reset
//  ce        in   1          clock enable; 0 freezes all state and handshakes
//  wd_valid  in   1          key word offered
//  wd        in   NBYTES*DW  key word; char 0 = wd[NBYTES*DW-1 -: DW] (MSB first)
//  base_add  in   AW         start address, sampled with wd
//  wd_ready  out  1          1 only in IDLE with ce=1
//  out_valid out  1          out/add valid
//  out_ready in   1          downstream accepts the character
//  out       out  DW         character
//  add       out  AW         address of character
//  last      out  1          qualifies the final emitted character
//  done      out  1          one-cycle pulse after the stream ends
//  byte_cnt  out  4          characters emitted, valid while done=1
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid, out, add, last, done, byte_cnt = 0; wd_ready=1 when ce=1.
//  - Word transfer on wd_valid & wd_ready & ce. Word and base_add go into a shift
//    register and address counter. wd_valid is ignored while not in IDLE (no queueing).
//  - FSM: IDLE -> SHIFT on transfer; SHIFT -> DONE after the last character transfer
//    (out_valid & out_ready & ce) or on terminator; DONE -> IDLE after exactly one cycle.
//  - Latency: word accepted in cycle N -> first out_valid in cycle N+1. With out_ready=1,
//    one character per cycle. done is asserted in the cycle after the last transfer.
//  - Stall: while out_valid=1 and out_ready=0, out/add/last hold stable.
//  - Each transfer shifts the word left by DW and increments add by 1 (modulo 2**AW).
//  - Terminator (TERM_EN=1): when the next character equals TERM, it is not presented.
//    The preceding character carries last=1. If char 0 is TERM, go directly to DONE with
//    byte_cnt=0 and never raise out_valid.
//  - TERM_EN=0: all NBYTES characters are emitted, TERM included; last is on char NBYTES-1.
//  - ce=0: no state, counter or output changes; wd_ready=0.
//  - rst mid-stream: in the next cycle, out_valid=0 and state=IDLE; no done pulse is produced.
//  - byte_cnt is 4 bits and saturates at 15; NBYTES must be <= 15.
// STRUCTURE
//  - Shared package: state encoding (IDLE/SHIFT/DONE), KEY_W = NBYTES*DW, TERM constant.
//  - Single module with no sub-modules; terminator lookahead is taken from the top DW
//    bits of the shift register.
// TESTING
//  1. wd="HELLOWORLD" (ASCII), base_add=0, out_ready=1 -> 'H'..'D' at add 0..9 on 10
//     consecutive cycles, last on 'D', done next cycle with byte_cnt=10.
//  2. wd="KEY" followed by 7x 8'h00, TERM_EN=1 -> 'K','E','Y' at add 0..2, last on 'Y',
//     done with byte_cnt=3.
//  3. base_add=8'hFC, 10 characters -> add FC,FD,FE,FF,00,01,02,03,04,05.
//  4. out_ready=0 for 3 cycles on char 4 -> out/add held; total 13 cycles to done; no
//     characters lost or duplicated.
//  5. ce=0 for 4 cycles mid-stream, with wd_valid pulsed at the same time -> outputs frozen,
//     new word ignored, stream resumes intact.
//  6. rst=1 after 4 characters -> next cycle out_valid=0, wd_ready=1, no done; a following
//     word decodes normally.

Source files
------------

// File: rtl/key_decoder_pkg.sv
// key_decoder_pkg
//   Shared constants and types for the key decoder slice.
//   NBYTES  characters per packed key word
//   DW      character width
//   AW      address width (addresses wrap modulo 2**AW)
//   KEY_W   packed key word width
//   TERM    terminator character
//   state_t decoder FSM encoding (IDLE / SHIFT / DONE)
package key_decoder_pkg;

   localparam int NBYTES = 10;
   localparam int DW     = 8;
   localparam int AW     = 8;
   localparam int KEY_W  = NBYTES * DW;

   localparam logic [DW-1:0] TERM = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/key_decoder_if.sv
// key_decoder_if
//   Bundles the key-word input handshake and the character output handshake.
//   Handshake rule, both channels: a beat moves on a rising clk edge where
//   valid & ready & ce are all 1; the producer holds its payload stable while
//   valid=1 and ready=0, and valid never depends combinationally on ready.
//   Signals
//     wd_valid / wd_ready  key word offered / decoder idle and enabled
//     wd, base_add         packed key word (char 0 in the MSBs), start address
//     out_valid/out_ready  character offered / downstream accepts
//     out, add, last       character, its address, final-character flag
//     done, byte_cnt       end-of-stream pulse and number of characters emitted
//   Modports
//     slave   decoder side
//     master  key-store / downstream side
interface key_decoder_if;
   import key_decoder_pkg::*;

   logic             wd_valid;
   logic             wd_ready;
   logic [KEY_W-1:0] wd;
   logic [AW-1:0]    base_add;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out;
   logic [AW-1:0]    add;
   logic             last;
   logic             done;
   logic [3:0]       byte_cnt;

   modport slave (
      input  wd_valid, wd, base_add, out_ready,
      output wd_ready, out_valid, out, add, last, done, byte_cnt
   );

   modport master (
      output wd_valid, wd, base_add, out_ready,
      input  wd_ready, out_valid, out, add, last, done, byte_cnt
   );

endinterface

// File: rtl/key_decoder.sv
// key_decoder
//   Unpacks one key word (NBYTES characters, MSB first) into a character
//   stream, one character per accepted cycle, each tagged with base_add+index.
//   With TERM_EN=1 the stream stops before the first TERM character.
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     ce         clock enable; 0 freezes all state, wd_ready forced to 0
//     bus        key_decoder_if.slave (word in, character out, done/byte_cnt)
//     state_dbg  current FSM state
module key_decoder
   import key_decoder_pkg::*;
#(
   parameter bit TERM_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   key_decoder_if.slave        bus,
   output state_t              state_dbg
);

   state_t           state;
   // Holds the characters not yet presented; its top DW bits are the next
   // character, which gives the terminator lookahead for free.
   logic [KEY_W-1:0] sr;
   logic [DW-1:0]    out_r;
   logic [AW-1:0]    add_r;
   logic             out_valid_r;
   logic             last_r;
   logic             done_r;
   logic [3:0]       cnt;        // characters presented so far in this word
   logic [3:0]       byte_cnt_r;

   logic [DW-1:0]    wd_c0;
   logic [DW-1:0]    wd_c1;
   logic [DW-1:0]    sr_c0;
   logic [DW-1:0]    sr_c1;

   assign wd_c0 = bus.wd[KEY_W-1 -: DW];
   assign wd_c1 = bus.wd[KEY_W-DW-1 -: DW];
   assign sr_c0 = sr[KEY_W-1 -: DW];
   assign sr_c1 = sr[KEY_W-DW-1 -: DW];

   function automatic logic is_term(input logic [DW-1:0] c);
      return TERM_EN && (c == TERM);
   endfunction

   assign bus.wd_ready  = ce && (state == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.out       = out_r;
   assign bus.add       = add_r;
   assign bus.last      = last_r;
   assign bus.done      = done_r;
   assign bus.byte_cnt  = byte_cnt_r;
   assign state_dbg     = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sr          <= '0;
         out_r       <= '0;
         add_r       <= '0;
         out_valid_r <= 1'b0;
         last_r      <= 1'b0;
         done_r      <= 1'b0;
         cnt         <= '0;
         byte_cnt_r  <= '0;
      end else if (ce) begin
         case (state)
            IDLE: begin
               if (bus.wd_valid) begin
                  // Char 0 goes straight to the output register; sr keeps the rest.
                  sr    <= bus.wd << DW;
                  add_r <= bus.base_add;
                  if (is_term(wd_c0)) begin
                     // Empty key: report zero characters without raising out_valid.
                     state      <= DONE;
                     done_r     <= 1'b1;
                     byte_cnt_r <= '0;
                     cnt        <= '0;
                  end else begin
                     state       <= SHIFT;
                     out_valid_r <= 1'b1;
                     out_r       <= wd_c0;
                     cnt         <= 4'd1;
                     last_r      <= is_term(wd_c1);
                  end
               end
            end

            SHIFT: begin
               if (bus.out_ready) begin
                  if (last_r) begin
                     out_valid_r <= 1'b0;
                     last_r      <= 1'b0;
                     state       <= DONE;
                     done_r      <= 1'b1;
                     byte_cnt_r  <= cnt;
                  end else begin
                     out_r  <= sr_c0;
                     sr     <= sr << DW;
                     add_r  <= add_r + 1'b1;
                     cnt    <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                     // The character now being presented has index cnt.
                     last_r <= (cnt == 4'(NBYTES - 1)) || is_term(sr_c1);
                  end
               end
            end

            DONE: begin
               done_r     <= 1'b0;
               byte_cnt_r <= '0;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_decoder.sv
module tb_key_decoder;
   import key_decoder_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic   clk = 1'b0;
   logic   rst;
   logic   ce;
   state_t state_dbg;

   key_decoder_if kif ();

   key_decoder #(.TERM_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .bus       (kif),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   // Expected stream entries: {char, address, last}
   logic [16:0] exp_q[$];
   int          m_phase = 0;   // 0 idle, 1 streaming, 2 done pulse
   int          m_bytes = 0;

   // Observed-transfer log used by the directed literal checks
   logic [7:0] lg_char[$];
   logic [7:0] lg_add[$];
   logic       lg_last[$];
   int         done_cnt     = 0;
   int         last_bcnt    = 0;
   int         valid_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   function automatic logic [31:0] phase_state(input int ph);
      if (ph == 0) return 32'(IDLE);
      if (ph == 1) return 32'(SHIFT);
      return 32'(DONE);
   endfunction

   // ---------------- model + compare (every cycle, falling edge) ----------------
   always @(negedge clk) begin
      logic [79:0] w;
      int          n;
      logic [7:0]  c;
      if (chk_en) begin
         chk("wd_ready",  32'(kif.wd_ready),  32'(m_phase == 0 && ce));
         chk("out_valid", 32'(kif.out_valid), 32'(m_phase == 1));
         chk("done",      32'(kif.done),      32'(m_phase == 2));
         chk("state",     32'(state_dbg),     phase_state(m_phase));
         if (m_phase == 1 && exp_q.size() > 0) begin
            chk("out",  32'(kif.out),  32'(exp_q[0][16:9]));
            chk("add",  32'(kif.add),  32'(exp_q[0][8:1]));
            chk("last", 32'(kif.last), 32'(exp_q[0][0]));
         end
         if (m_phase == 2) chk("byte_cnt", 32'(kif.byte_cnt), 32'(m_bytes));

         if (kif.out_valid) valid_cycles++;
         if (kif.done) begin
            done_cnt++;
            last_bcnt = int'(kif.byte_cnt);
         end
         if (!rst && ce && kif.out_valid && kif.out_ready) begin
            lg_char.push_back(kif.out);
            lg_add.push_back(kif.add);
            lg_last.push_back(kif.last);
         end

         // Advance the model to what the next cycle must show.
         if (rst) begin
            m_phase = 0;
            exp_q.delete();
         end else if (ce) begin
            case (m_phase)
               0: if (kif.wd_valid) begin
                  w = kif.wd;
                  n = NBYTES;
                  for (int i = NBYTES - 1; i >= 0; i--)
                     if (w[79 - 8*i -: 8] == TERM) n = i;
                  for (int i = 0; i < n; i++) begin
                     c = w[79 - 8*i -: 8];
                     exp_q.push_back({c, 8'(kif.base_add + 8'(i)), 1'(i == n - 1)});
                  end
                  m_bytes = 0;
                  m_phase = (n == 0) ? 2 : 1;
               end
               1: if (kif.out_ready) begin
                  void'(exp_q.pop_front());
                  m_bytes++;
                  if (exp_q.size() == 0) m_phase = 2;
               end
               default: m_phase = 0;
            endcase
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      lg_char.delete();
      lg_add.delete();
      lg_last.delete();
      valid_cycles = 0;
   endtask

   task automatic send_word(input logic [79:0] w, input logic [7:0] b);
      bit acc;
      kif.wd       = w;
      kif.base_add = b;
      kif.wd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         acc = kif.wd_ready;
         tick();
         if (acc) begin
            kif.wd_valid = 1'b0;
            return;
         end
      end
      kif.wd_valid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_cnt > d0) return;
      end
      chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_chars(input int n);
      for (int i = 0; i < 40; i++) begin
         if (lg_char.size() >= n) return;
         tick();
      end
      chk("chars_timeout", 32'(lg_char.size()), 32'(n));
   endtask

   task automatic check_str(input string s, input int n, input logic [7:0] b);
      chk("n_chars", 32'(lg_char.size()), 32'(n));
      for (int i = 0; i < n && i < lg_char.size(); i++) begin
         chk("str_char", 32'(lg_char[i]), 32'(s[i]));
         chk("str_add",  32'(lg_add[i]),  32'(8'(b + 8'(i))));
         chk("str_last", 32'(lg_last[i]), 32'(i == n - 1));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [79:0] hello;
      logic [79:0] digits;
      int          d0;
      hello  = "HELLOWORLD";
      digits = "0123456789";

      rst = 1'b1;
      ce  = 1'b1;
      kif.wd_valid  = 1'b0;
      kif.wd        = '0;
      kif.base_add  = '0;
      kif.out_ready = 1'b1;
      tick();
      tick();
      chk_en = 1'b1;

      // Reset state
      chk("rst_out_valid", 32'(kif.out_valid), 32'd0);
      chk("rst_out",       32'(kif.out),       32'd0);
      chk("rst_add",       32'(kif.add),       32'd0);
      chk("rst_last",      32'(kif.last),      32'd0);
      chk("rst_done",      32'(kif.done),      32'd0);
      chk("rst_byte_cnt",  32'(kif.byte_cnt),  32'd0);
      chk("rst_wd_ready",  32'(kif.wd_ready),  32'd1);
      rst = 1'b0;
      tick();

      // 1: full word, back-to-back characters
      clear_logs();
      send_word(hello, 8'h00);
      wait_done(40);
      check_str("HELLOWORLD", 10, 8'h00);
      chk("t1_bcnt",   32'(last_bcnt),    32'd10);
      chk("t1_cycles", 32'(valid_cycles), 32'd10);

      // 2: terminator after three characters
      clear_logs();
      send_word(80'h4B4559_00000000000000, 8'h00);
      wait_done(40);
      check_str("KEY", 3, 8'h00);
      chk("t2_bcnt", 32'(last_bcnt), 32'd3);

      // 3: address wrap
      clear_logs();
      send_word(digits, 8'hFC);
      wait_done(40);
      check_str("0123456789", 10, 8'hFC);
      chk("t3_add4", 32'(lg_add.size() > 4 ? lg_add[4] : 8'hAA), 32'h00);
      chk("t3_add9", 32'(lg_add.size() > 9 ? lg_add[9] : 8'hAA), 32'h05);

      // 4: three-cycle stall on char 4
      clear_logs();
      send_word(hello, 8'h20);
      wait_chars(4);
      kif.out_ready = 1'b0;
      repeat (3) tick();
      kif.out_ready = 1'b1;
      wait_done(40);
      check_str("HELLOWORLD", 10, 8'h20);
      chk("t4_cycles", 32'(valid_cycles), 32'd13);
      chk("t4_bcnt",   32'(last_bcnt),    32'd10);

      // 5: clock enable dropped mid-stream while a new word is offered
      clear_logs();
      send_word(hello, 8'h40);
      wait_chars(3);
      ce = 1'b0;
      kif.wd = "ZZZZZZZZZZ";
      kif.wd_valid = 1'b1;
      repeat (4) tick();
      ce = 1'b1;
      kif.wd_valid = 1'b0;
      wait_done(40);
      check_str("HELLOWORLD", 10, 8'h40);
      chk("t5_bcnt", 32'(last_bcnt), 32'd10);

      // 6: reset after four characters, then a clean word
      clear_logs();
      send_word(hello, 8'h00);
      wait_chars(4);
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_out_valid", 32'(kif.out_valid), 32'd0);
      chk("t6_wd_ready",  32'(kif.wd_ready),  32'd1);
      repeat (5) tick();
      chk("t6_no_done", 32'(done_cnt), 32'(d0));
      clear_logs();
      send_word(hello, 8'h10);
      wait_done(40);
      check_str("HELLOWORLD", 10, 8'h10);

      // Terminator as char 0: done with zero characters, no out_valid
      clear_logs();
      send_word(80'h0, 8'h05);
      wait_done(10);
      chk("t7_bcnt",   32'(last_bcnt),      32'd0);
      chk("t7_valid",  32'(valid_cycles),   32'd0);
      chk("t7_nchars", 32'(lg_char.size()), 32'd0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
